// File: rtl/acc_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : acc_pipe
//  Purpose  : Carry-segmented pipelined adder computing
//             data_in1 + data_in2 + data_cin over SEGS stages, one
//             WIDTH/SEGS-bit slice per stage. Valid/ready handshake with a
//             single global stall, plus an optional signed-saturation mode.
//  Ports    : clk, reset (sync, active-high), enable (global advance)
//             in_valid/in_ready, data_in1, data_in2, data_cin, sat_en : input beat
//             out_valid/out_ready, data_out (WIDTH+1, MSB = carry-out), ovf
//  Revision : 1.0  initial release
// ============================================================================
module acc_pipe #(
    parameter int WIDTH = 128,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic             data_cin,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   data_out,
    output logic             ovf
);

    localparam int SW = WIDTH / SEGS;

    logic             w_adv;
    logic             w_acc;
    logic [WIDTH-1:0] w_fsum;
    logic             w_fc;
    logic             w_fv;
    logic             w_fs;
    logic             w_fsa;
    logic             w_fsb;
    logic             w_ovf;

    // One stall signal for the whole pipe: it moves only when the output
    // slot is free or being drained this cycle.
    assign w_adv     = enable & (~w_fv | out_ready);
    assign w_acc     = in_valid & w_adv;
    assign in_ready  = w_adv;
    assign out_valid = w_fv;

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        localparam int LO = k * SW;       // first bit of this stage's slice
        localparam int RW = WIDTH - LO;   // operand bits not yet consumed

        logic [RW-1:0]    w_ra;
        logic [RW-1:0]    w_rb;
        logic             w_ci;
        logic             w_vi;
        logic             w_si;
        logic             w_sai;
        logic             w_sbi;
        logic             w_ld;
        logic [SW:0]      w_add;
        logic [LO+SW-1:0] w_sum_nx;

        logic             r_v;
        logic             r_s;
        logic             r_c;
        logic             r_sa;
        logic             r_sb;
        logic [LO+SW-1:0] r_sum;

        if (k == 0) begin : g_first
            // Stage 0 captures operands only on accept; a bubble leaves the
            // data registers untouched and just clears valid.
            assign w_ra     = data_in1;
            assign w_rb     = data_in2;
            assign w_ci     = data_cin;
            assign w_vi     = w_acc;
            assign w_si     = sat_en;
            assign w_sai    = data_in1[WIDTH-1];
            assign w_sbi    = data_in2[WIDTH-1];
            assign w_ld     = w_acc;
            assign w_sum_nx = w_add[SW-1:0];
        end else begin : g_next
            assign w_ra     = g_stage[k-1].g_rem.r_ra;
            assign w_rb     = g_stage[k-1].g_rem.r_rb;
            assign w_ci     = g_stage[k-1].r_c;
            assign w_vi     = g_stage[k-1].r_v;
            assign w_si     = g_stage[k-1].r_s;
            assign w_sai    = g_stage[k-1].r_sa;
            assign w_sbi    = g_stage[k-1].r_sb;
            assign w_ld     = w_adv;
            assign w_sum_nx = {w_add[SW-1:0], g_stage[k-1].r_sum};
        end

        assign w_add = {1'b0, w_ra[SW-1:0]} + {1'b0, w_rb[SW-1:0]}
                     + {{SW{1'b0}}, w_ci};

        always_ff @(posedge clk) begin
            if (reset) begin
                r_v   <= 1'b0;
                r_s   <= 1'b0;
                r_c   <= 1'b0;
                r_sa  <= 1'b0;
                r_sb  <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_v <= w_vi;
                if (w_ld) begin
                    r_s   <= w_si;
                    r_c   <= w_add[SW];
                    r_sa  <= w_sai;
                    r_sb  <= w_sbi;
                    r_sum <= w_sum_nx;
                end
            end
        end

        // Upper operand slices still waiting for their stage.
        if (k < SEGS - 1) begin : g_rem
            logic [RW-SW-1:0] r_ra;
            logic [RW-SW-1:0] r_rb;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ra <= '0;
                    r_rb <= '0;
                end else if (w_adv && w_ld) begin
                    r_ra <= w_ra[RW-1:SW];
                    r_rb <= w_rb[RW-1:SW];
                end
            end
        end

        if (k == SEGS - 1) begin : g_last
            assign w_fsum = r_sum;
            assign w_fc   = r_c;
            assign w_fv   = r_v;
            assign w_fs   = r_s;
            assign w_fsa  = r_sa;
            assign w_fsb  = r_sb;
        end
    end

    // Result formatting is combinational off the last stage registers, so
    // it holds exactly as long as those registers do and clears with reset.
    assign w_ovf = (w_fsa == w_fsb) & (w_fsum[WIDTH-1] != w_fsa);

    always_comb begin
        data_out = {w_fc, w_fsum};
        ovf      = w_ovf;
        if (w_fs) begin
            if (!w_ovf) begin
                data_out = {1'b0, w_fsum};
            end else if (!w_fsa) begin
                data_out = {2'b00, {(WIDTH-1){1'b1}}};
            end else begin
                data_out = {2'b01, {(WIDTH-1){1'b0}}};
            end
        end
    end

endmodule
`default_nettype wire
